// File: rtl/audio_sample_scheduler_if.sv
// Bundle of source-side and audio-output-side signals for the sample scheduler.
// The master modport is the scheduler; the slave modport is the sources plus the audio output.
interface audio_sample_scheduler_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = 2
) ();
    logic                    enable;
    logic [NUM_SRC-1:0]      src_valid;
    logic [32*NUM_SRC-1:0]   src_data;
    logic [NUM_SRC-1:0]      mute_mask;
    logic [NUM_SRC-1:0]      src_ready;
    logic [31:0]             out_data;
    logic                    out_valid_toggle;
    logic                    out_full;
    logic [SRC_W-1:0]        grant_id;
    logic [31:0]             sample_count;

    modport master (
        input  enable, src_valid, src_data, mute_mask, out_full,
        output src_ready, out_data, out_valid_toggle, grant_id, sample_count
    );

    modport slave (
        output enable, src_valid, src_data, mute_mask, out_full,
        input  src_ready, out_data, out_valid_toggle, grant_id, sample_count
    );
endinterface

// File: rtl/audio_sample_scheduler.sv
// Round-robin scheduler that moves one PCM sample at a time from NUM_SRC sources to an
// audio output signalled by a valid toggle, with a fixed HOLD gap after each toggle.
module audio_sample_scheduler #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned GAP     = 4,
    parameter int unsigned SRC_W   = 2
) (
    input logic                    clk,
    input logic                    reset,
    audio_sample_scheduler_if.master bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e             state_q;
    logic [SRC_W-1:0]   ptr_q;
    logic [SRC_W-1:0]   grant_q;
    logic [NUM_SRC-1:0] ready_q;
    logic [31:0]        data_q;
    logic [31:0]        count_q;
    logic               toggle_q;
    logic [3:0]         hold_q;

    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   idx;
    logic               win_found;
    logic               grant_ok;

    // First valid source at or after the pointer, wrapping modulo NUM_SRC.
    always_comb begin
        win       = '0;
        idx       = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = SRC_W'((32'(ptr_q) + k) % NUM_SRC);
            if (!win_found && bus.src_valid[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    assign grant_ok = bus.enable && !bus.out_full && win_found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            grant_q  <= '0;
            ready_q  <= '0;
            data_q   <= '0;
            count_q  <= '0;
            toggle_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_ok) begin
                        data_q  <= bus.mute_mask[win] ? 32'h8000_8000
                                                      : bus.src_data[32*win +: 32];
                        ready_q <= NUM_SRC'(1) << win;
                        grant_q <= win;
                        ptr_q   <= SRC_W'((32'(win) + 1) % NUM_SRC);
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    ready_q  <= '0;
                    toggle_q <= ~toggle_q;
                    count_q  <= count_q + 32'd1;
                    hold_q   <= 4'(GAP - 1);
                    state_q  <= StHold;
                end
                StHold: begin
                    // Gap lets the output see the toggle and settle its full flag.
                    if (hold_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        hold_q <= hold_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.src_ready        = ready_q;
    assign bus.out_data         = data_q;
    assign bus.out_valid_toggle = toggle_q;
    assign bus.grant_id         = grant_q;
    assign bus.sample_count     = count_q;

endmodule
